ts_bus_master: RTL
==================

// Module: ts_bus_master
// PURPOSE
//  Host-side initiator for the Turbosound-FM PSG bus (BDIR/BC/DI).
//  - Turns single-register read/write requests (chip, addr, data) into timed bus phases:
//    chip-select command, address latch, data write or data read.
//  - Sits between the CPU port decoder and the turbosound block.
//  - Phase widths are sized for a receiver that double-registers the bus and acts on the BDIR rising edge.
// PARAMETERS
//  SETUP_CYCLES  2  clocks DI/BC stable with BDIR=0 before strobe (>=1)
//  STROBE_CYCLES 4  clocks BDIR=1 per write-type phase (>=3)
//  HOLD_CYCLES   2  clocks DI/BC held after BDIR falls (>=1)
//  READ_CYCLES   6  clocks BC=1,BDIR=0 before DI_BUS is sampled (>=4)
// PORTS
//  CLK        in  1  system clock
//  RESET_N    in  1  synchronous reset, active low
//  REQ_VALID  in  1  request valid
//  REQ_READY  out 1  high only in IDLE
//  REQ_READ   in  1  1=read, 0=write
//  REQ_CHIP   in  1  target chip (0/1)
//  REQ_ADDR   in  8  register address
//  REQ_DATA   in  8  write data
//  FM_EN      in  1  FM enable; goes into select command
//  STAT_SEL   in  1  status-select bit; goes into select command
//  RSP_VALID  out 1  1-cycle pulse, read data valid
//  RSP_DATA   out 8  read data
//  BDIR       out 1  bus direction strobe
//  BC         out 1  bus control
//  DO_BUS     out 8  data to receiver DI
//  DI_BUS     in  8  data from receiver DO
//  BUSY       out 1  ~REQ_READY
// BEHAVIOUR
//  - Reset, when RESET_N=0 at a CLK edge:
//    - State goes to IDLE; BDIR=0, BC=0, DO_BUS=8'h00, RSP_VALID=0, RSP_DATA=8'h00.
//    - Select shadow is invalidated.
//    - Reset mid-transaction aborts it; the bus is idle on the next clock; no RSP_VALID is issued.
//  - Accept: REQ_VALID&REQ_READY in IDLE latches REQ_*, FM_EN and STAT_SEL. Config is sampled only here.
//  - Select command: sel_cmd = {5'b11111, ~FM_EN, STAT_SEL, REQ_CHIP}.
//    - Emitted as an SEL phase if the shadow is invalid or differs from sel_cmd.
//    - Afterwards shadow <= sel_cmd and valid <= 1.
//  - Write-type phase (SEL/ADR/DAT), each SETUP+STROBE+HOLD clocks:
//    - SETUP:  DO_BUS=byte, BC=kind, BDIR=0.
//    - STROBE: BDIR=1.
//    - HOLD:   BDIR=0.
//    - BC=1 for SEL and ADR; BC=0 for DAT. DO_BUS and BC are constant across the whole phase.
//  - FSM:
//    - IDLE -> SEL_* (if needed) -> ADR_* -> (write ? DAT_* : RD) -> IDLE.
//    - Each *_SETUP/_STROBE/_HOLD state is left when its counter reaches N-1.
//  - RD: BC=1, BDIR=0, DO_BUS=8'hFF for READ_CYCLES clocks.
//    - DI_BUS is registered on the last RD clock.
//    - RSP_VALID pulses the following clock with RSP_DATA, coincident with the return to IDLE.
//  - Between phases and in IDLE: BDIR=0, BC=0; DO_BUS keeps its last value.
//  - BDIR is never 1 on two consecutive phases without >= HOLD+SETUP low clocks between them.
//  - Latency, default params (1 IDLE clock per transaction in addition):
//    - write: 16 clocks, or 24 with SEL.
//    - read: 14 clocks, or 22 with SEL.
// CONFIGURATION
//  - TS_ADDR_CACHE_EN defined:
//    - Keeps last_addr/valid for the currently selected chip.
//    - A write whose chip and addr match skips the ADR phase (DAT only, 8 clocks).
//    - Any SEL phase or reset invalidates the cache; reads always emit ADR and refresh the cache.
//  - TS_ADDR_CACHE_EN undefined: ADR is always emitted; no cache registers exist.
// STRUCTURE
//  - Package ts_bus_pkg holds:
//    - SEL_PREFIX = 5'b11111.
//    - state enum: IDLE, SEL_SETUP, SEL_STROBE, SEL_HOLD, ADR_*, DAT_*, RD.
//    - phase-kind typedef.
//  - Sub-module ts_bus_phase_timer: loadable down-counter with a done flag, shared by all phases.
// TESTING
//  1. Reset; write chip0 addr 8'h07 data 8'h38, FM_EN=1, STAT_SEL=1:
//     -> three BDIR pulses with DO_BUS 8'hFA (BC=1), 8'h07 (BC=1), 8'h38 (BC=0); REQ_READY back after 24 clocks.
//  2. Then write chip0 addr 8'h08 data 8'h0F:
//     -> no select; two BDIR pulses; 16 clocks.
//  3. Write chip1 addr 8'h00 data 8'h55:
//     -> select byte 8'hFB first; the turbosound checker shows chip1 reg0 = 8'h55.
//  4. Read chip1 addr 8'h07, DI_BUS model driving 8'h5A:
//     -> BDIR pulses only for ADR; RSP_VALID for 1 clock with RSP_DATA=8'h5A.
//  5. RESET_N low during DAT_STROBE:
//     -> next clock BDIR=0, BC=0; no RSP_VALID; the next request re-emits the select command.
//  6. TS_ADDR_CACHE_EN: two writes chip0 addr 8'h07 (8'h01, 8'h02):
//     -> the second write shows only a BC=0 pulse (8 clocks); an FM_EN toggle forces SEL+ADR again.

Source files
------------

// File: rtl/ts_bus_pkg.sv
// Shared types and helpers for the Turbosound-FM PSG bus master (optional macro: TS_ADDR_CACHE_EN).
// Holds the select-command prefix, FSM state encoding and phase-kind classification.
package ts_bus_pkg;

  localparam logic [4:0] SEL_PREFIX = 5'b11111;
  localparam int         CNT_W      = 8;

  typedef enum logic [3:0] {
    IDLE,
    SEL_SETUP,
    SEL_STROBE,
    SEL_HOLD,
    ADR_SETUP,
    ADR_STROBE,
    ADR_HOLD,
    DAT_SETUP,
    DAT_STROBE,
    DAT_HOLD,
    RD
  } state_t;

  typedef enum logic [2:0] {
    PH_NONE,
    PH_SEL,
    PH_ADR,
    PH_DAT,
    PH_RD
  } phase_kind_t;

  function automatic logic [7:0] sel_cmd(input logic fm_en, input logic stat_sel,
                                         input logic chip);
    return {SEL_PREFIX, ~fm_en, stat_sel, chip};
  endfunction

  function automatic phase_kind_t state_kind(input state_t s);
    phase_kind_t k;
    case (s)
      SEL_SETUP, SEL_STROBE, SEL_HOLD: k = PH_SEL;
      ADR_SETUP, ADR_STROBE, ADR_HOLD: k = PH_ADR;
      DAT_SETUP, DAT_STROBE, DAT_HOLD: k = PH_DAT;
      RD:                              k = PH_RD;
      default:                         k = PH_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ts_bus_phase_timer.sv
// Loadable down-counter shared by every bus phase; o_done is high while the count is zero.
// Loading N-1 on state entry makes the state last exactly N clocks.
module ts_bus_phase_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/ts_bus_master.sv
// Turbosound-FM PSG bus initiator: turns register read/write requests into timed BDIR/BC/DI phases.
// Optional macro TS_ADDR_CACHE_EN lets a repeated write to the same chip/address skip the ADR phase.
module ts_bus_master #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2,
  parameter int READ_CYCLES   = 6
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_read,
  input  logic       i_req_chip,
  input  logic [7:0] i_req_addr,
  input  logic [7:0] i_req_data,
  input  logic       i_fm_en,
  input  logic       i_stat_sel,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_data,
  output logic       o_bdir,
  output logic       o_bc,
  output logic [7:0] o_do_bus,
  input  logic [7:0] i_di_bus,
  output logic       o_busy,
  output logic [3:0] o_dbg_state
);
  import ts_bus_pkg::*;

  // Handshake: a request transfers on a clock where i_req_valid && o_req_ready; ready is
  // high only in IDLE, and all request fields plus FM/status config are captured then.

  state_t      r_state;
  state_t      w_state_next;
  phase_kind_t w_kind;

  logic       r_read;
  logic [7:0] r_addr;
  logic [7:0] r_data;
  logic [7:0] r_sel_shadow;
  logic       r_sel_vld;
  logic [7:0] r_do_bus;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_data;

  logic             w_accept;
  logic             w_need_sel;
  logic             w_skip_adr;
  logic [7:0]       w_sel_cmd;
  logic             w_timer_done;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_do_load;
  logic [7:0]       w_do_next;
  logic             w_rd_last;

`ifdef TS_ADDR_CACHE_EN
  logic [7:0] r_cache_addr;
  logic       r_cache_vld;
`endif

  always_comb begin
    w_sel_cmd  = sel_cmd(i_fm_en, i_stat_sel, i_req_chip);
    w_need_sel = !r_sel_vld || (r_sel_shadow != w_sel_cmd);
    w_accept   = i_req_valid && (r_state == IDLE);
    w_rd_last  = (r_state == RD) && w_timer_done;
`ifdef TS_ADDR_CACHE_EN
    // Unchanged select means the same chip is addressed, so a matching cached address is valid.
    w_skip_adr = !i_req_read && !w_need_sel && r_cache_vld && (r_cache_addr == i_req_addr);
`else
    w_skip_adr = 1'b0;
`endif
  end

  always_comb begin
    w_state_next = r_state;
    w_do_load    = 1'b0;
    w_do_next    = r_do_bus;
    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          w_do_load = 1'b1;
          if (w_need_sel) begin
            w_state_next = SEL_SETUP;
            w_do_next    = w_sel_cmd;
          end else if (w_skip_adr) begin
            w_state_next = DAT_SETUP;
            w_do_next    = i_req_data;
          end else begin
            w_state_next = ADR_SETUP;
            w_do_next    = i_req_addr;
          end
        end
      end
      SEL_SETUP:  if (w_timer_done) w_state_next = SEL_STROBE;
      SEL_STROBE: if (w_timer_done) w_state_next = SEL_HOLD;
      SEL_HOLD: begin
        if (w_timer_done) begin
          w_state_next = ADR_SETUP;
          w_do_load    = 1'b1;
          w_do_next    = r_addr;
        end
      end
      ADR_SETUP:  if (w_timer_done) w_state_next = ADR_STROBE;
      ADR_STROBE: if (w_timer_done) w_state_next = ADR_HOLD;
      ADR_HOLD: begin
        if (w_timer_done) begin
          w_do_load = 1'b1;
          if (r_read) begin
            w_state_next = RD;
            w_do_next    = 8'hFF;
          end else begin
            w_state_next = DAT_SETUP;
            w_do_next    = r_data;
          end
        end
      end
      DAT_SETUP:  if (w_timer_done) w_state_next = DAT_STROBE;
      DAT_STROBE: if (w_timer_done) w_state_next = DAT_HOLD;
      DAT_HOLD:   if (w_timer_done) w_state_next = IDLE;
      RD:         if (w_timer_done) w_state_next = IDLE;
      default:    w_state_next = IDLE;
    endcase
  end

  // Every state change reloads the timer with the duration of the state being entered.
  always_comb begin
    w_load = (w_state_next != r_state);
    case (w_state_next)
      SEL_SETUP, ADR_SETUP, DAT_SETUP:    w_load_val = CNT_W'(SETUP_CYCLES - 1);
      SEL_STROBE, ADR_STROBE, DAT_STROBE: w_load_val = CNT_W'(STROBE_CYCLES - 1);
      SEL_HOLD, ADR_HOLD, DAT_HOLD:       w_load_val = CNT_W'(HOLD_CYCLES - 1);
      RD:                                 w_load_val = CNT_W'(READ_CYCLES - 1);
      default:                            w_load_val = '0;
    endcase
  end

  ts_bus_phase_timer #(
    .W(CNT_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_timer_done)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_read       <= 1'b0;
      r_addr       <= 8'h00;
      r_data       <= 8'h00;
      r_sel_shadow <= 8'h00;
      r_sel_vld    <= 1'b0;
      r_do_bus     <= 8'h00;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= 8'h00;
    end else begin
      r_state     <= w_state_next;
      r_rsp_valid <= w_rd_last;
      if (w_do_load) r_do_bus <= w_do_next;
      if (w_rd_last) r_rsp_data <= i_di_bus;
      if (w_accept) begin
        r_read       <= i_req_read;
        r_addr       <= i_req_addr;
        r_data       <= i_req_data;
        // A select phase is always completed unless reset intervenes, and reset clears this.
        r_sel_shadow <= w_sel_cmd;
        r_sel_vld    <= 1'b1;
      end
    end
  end

`ifdef TS_ADDR_CACHE_EN
  // After any accepted request the receiver's address latch ends up holding i_req_addr:
  // either ADR is emitted (also after a select) or the cached value already matched.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cache_addr <= 8'h00;
      r_cache_vld  <= 1'b0;
    end else if (w_accept) begin
      r_cache_addr <= i_req_addr;
      r_cache_vld  <= 1'b1;
    end
  end
`endif

  assign w_kind      = state_kind(r_state);
  assign o_bc        = (w_kind == PH_SEL) || (w_kind == PH_ADR) || (w_kind == PH_RD);
  assign o_bdir      = (r_state == SEL_STROBE) || (r_state == ADR_STROBE) ||
                       (r_state == DAT_STROBE);
  assign o_do_bus    = r_do_bus;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_req_ready = (r_state == IDLE);
  assign o_busy      = (r_state != IDLE);
  assign o_dbg_state = r_state;

endmodule
